// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: data-memory bus port of the UART transmitter
interface mmio_uart_tx_if;
  logic we;
  logic [31:0] a, wd, rd;
  modport master(output we, a, wd, input rd);
  modport slave(input we, a, wd, output rd);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO
module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
  input  logic clk,
  input  logic rst,
  mmio_uart_tx_if.slave bus,
  output logic tx,
  output logic busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] count;
  logic ovf, sel, wr_data, wr_stat, full, empty, pop, push, wrap, unused;
  assign sel = bus.a[31:3] == BASE_ADDR[31:3];
  assign wr_data = bus.we && sel && !bus.a[2];
  assign wr_stat = bus.we && sel && bus.a[2];
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign pop = state == IDLE && !empty;
  assign push = wr_data && (!full || pop);
  assign wrap = cnt == CW'(CLKS_PER_BIT - 1);
  assign busy = !empty || state != IDLE;
  assign bus.rd = sel && bus.a[2] ? {28'b0, ovf, busy, empty, full} : 32'b0;
  assign unused = ^{bus.wd[31:8], bus.a[1:0]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      tx <= 1'b1;
    end else begin
      cnt <= (state == IDLE || wrap) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (!empty) begin
          state <= START;
          shreg <= mem[rp];
          tx <= 1'b0;
        end
        START: if (wrap) begin
          state <= DATA;
          bit_idx <= '0;
          tx <= shreg[0];
        end
        DATA: if (wrap) begin
          shreg <= shreg >> 1;
          bit_idx <= bit_idx + 1'b1;
          state <= bit_idx == 3'd7 ? STOP : DATA;
          tx <= bit_idx == 3'd7 ? 1'b1 : shreg[1];
        end
        default: if (wrap) state <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      rp <= rp + AW'(pop);
      wp <= wp + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      ovf <= (wr_stat && bus.wd[3]) ? 1'b0 : ovf | (wr_data && !push);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= bus.wd[7:0];
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed self-checking bench for the MMIO UART transmitter
module tb_mmio_uart_tx;
  logic clk = 1'b0, rst = 1'b0;
  logic tx, busy;
  int n_tests = 0, n_fail = 0;
  bit found, bad;
  int w;
  logic [39:0] v;
  logic [31:0] st;
  mmio_uart_tx_if bus();
  mmio_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .BASE_ADDR(32'h100)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [39:0] fv(input logic [7:0] b);
    logic [9:0] f;
    logic [39:0] r;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) r[i] = f[i/4];
    return r;
  endfunction
  task automatic rx_frame(input int lim, output bit fnd, output int wt, output logic [39:0] vec, output logic [31:0] mid);
    fnd = 1'b0;
    wt = 0;
    vec = '0;
    mid = '0;
    while (!fnd && wt < lim) begin
      @(negedge clk);
      wt++;
      if (tx === 1'b0) fnd = 1'b1;
    end
    if (fnd) begin
      vec[0] = tx;
      for (int i = 1; i < 40; i++) begin
        @(negedge clk);
        vec[i] = tx;
        if (i == 20) mid = bus.rd;
      end
    end
  endtask
  task automatic wr(input logic [31:0] ad, input logic [31:0] d);
    bus.we = 1'b1;
    bus.a = ad;
    bus.wd = d;
    @(negedge clk);
    bus.we = 1'b0;
    bus.a = 32'h104;
  endtask
  initial begin
    bus.we = 1'b0;
    bus.a = 32'h104;
    bus.wd = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_status", bus.rd, 32'h2);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_status", bus.rd, 32'h2);
    bus.a = 32'h100;
    #1 chk("txdata_read_zero", bus.rd, 0);
    bus.a = 32'h104;
    @(negedge clk);
    wr(32'h100, 32'hA5);
    chk("t1_busy_after_store", busy, 1);
    rx_frame(100, found, w, v, st);
    chk("t1_found", found, 1);
    chk("t1_latency", w, 1);
    chk("t1_frame_a5", v, fv(8'hA5));
    chk("t1_busy_last_stop", busy, 1);
    @(negedge clk);
    chk("t1_busy_done", busy, 0);
    chk("t1_tx_idle", tx, 1);
    repeat (3) @(negedge clk);
    fork
      begin
        bus.we = 1'b1;
        bus.a = 32'h100;
        bus.wd = 32'h41;
        @(negedge clk);
        bus.wd = 32'h42;
        @(negedge clk);
        bus.we = 1'b0;
        bus.a = 32'h104;
      end
      begin
        rx_frame(10, found, w, v, st);
        chk("t2_frame_41", v, fv(8'h41));
        chk("t2_mid_status", st, 32'h4);
      end
    join
    rx_frame(10, found, w, v, st);
    chk("t2_gap", w, 2);
    chk("t2_frame_42", v, fv(8'h42));
    @(negedge clk);
    chk("t2_busy_done", busy, 0);
    repeat (3) @(negedge clk);
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          bus.we = 1'b1;
          bus.a = 32'h100;
          bus.wd = 32'h11 * (k + 1);
          @(negedge clk);
        end
        bus.we = 1'b0;
        bus.a = 32'h104;
        #1 chk("t3_full_ovf", bus.rd, 32'hD);
        bus.we = 1'b1;
        bus.wd = 32'h8;
        @(negedge clk);
        bus.we = 1'b0;
        #1 chk("t3_ovf_clear", bus.rd, 32'h5);
      end
      begin
        rx_frame(10, found, w, v, st);
        chk("t3_frame_11", v, fv(8'h11));
      end
    join
    for (int k = 2; k <= 5; k++) begin
      rx_frame(10, found, w, v, st);
      chk("t3_gap", w, 2);
      chk("t3_frame", v, fv(8'(8'h11 * k)));
    end
    rx_frame(60, found, w, v, st);
    chk("t3_dropped_not_sent", found, 0);
    chk("t3_status_idle", bus.rd, 32'h2);
    bus.we = 1'b1;
    bus.wd = 32'h77;
    bus.a = 32'h108;
    #1 chk("t4_rd_108", bus.rd, 0);
    @(negedge clk);
    bus.a = 32'h0FC;
    #1 chk("t4_rd_0fc", bus.rd, 0);
    @(negedge clk);
    bus.we = 1'b0;
    bus.a = 32'h104;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    chk("t4_no_frame", bad, 0);
    chk("t4_status", bus.rd, 32'h2);
    for (int k = 0; k < 3; k++) begin
      bus.we = 1'b1;
      bus.a = 32'h100;
      bus.wd = k == 0 ? 32'hFF : 32'(k);
      @(negedge clk);
    end
    bus.we = 1'b0;
    bus.a = 32'h104;
    repeat (16) @(negedge clk);
    #1 chk("t5_status_bit3", bus.rd, 32'h4);
    rst = 1'b0;
    #1 chk("t5_rst_tx", tx, 1);
    chk("t5_rst_status", bus.rd, 32'h2);
    chk("t5_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    chk("t5_no_more_frames", bad, 0);
    chk("t5_status_after", bus.rd, 32'h2);
    wr(32'h100, 32'h00);
    @(negedge clk);
    chk("t5b_start_low", tx, 0);
    #2 rst = 1'b0;
    #1 chk("t5b_async_tx", tx, 1);
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1'b1;
    end
    chk("t5b_quiet", bad, 0);
    fork
      begin
        for (int k = 1; k <= 5; k++) begin
          bus.we = 1'b1;
          bus.a = 32'h100;
          bus.wd = 32'hA0 + 32'(k);
          @(negedge clk);
        end
        bus.we = 1'b0;
        bus.a = 32'h104;
        #1 chk("t6_full", bus.rd, 32'h5);
      end
      begin
        rx_frame(10, found, w, v, st);
        chk("t6_frame_a1", v, fv(8'hA1));
      end
    join
    fork
      begin
        @(negedge clk);
        bus.we = 1'b1;
        bus.a = 32'h100;
        bus.wd = 32'h99;
        @(negedge clk);
        bus.we = 1'b0;
        bus.a = 32'h104;
        #1 chk("t6_pushpop_full", bus.rd, 32'h5);
      end
      begin
        rx_frame(10, found, w, v, st);
        chk("t6_gap", w, 2);
        chk("t6_frame_a2", v, fv(8'hA2));
      end
    join
    for (int k = 3; k <= 6; k++) begin
      rx_frame(10, found, w, v, st);
      chk("t6_frame", v, fv(k == 6 ? 8'h99 : 8'(8'hA0 + k)));
    end
    @(negedge clk);
    chk("t6_busy_done", busy, 0);
    chk("t6_status_end", bus.rd, 32'h2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
